// File: rtl/ascon_perm_sched_2rc_pkg.sv
// Shared encodings for the 2-rounds-per-cycle ASCON permutation sequencer:
// request modes, round-constant start values, round-pair counts, FSM states.
package ascon_sched_pkg;

    typedef enum logic [1:0] {
        MODE_P12 = 2'b00,
        MODE_P8  = 2'b01,
        MODE_P6  = 2'b10,
        MODE_ILL = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] START_P12 = 4'd0;
    localparam logic [3:0] START_P8  = 4'd4;
    localparam logic [3:0] START_P6  = 4'd6;

    localparam logic [2:0] PAIRS_P12 = 3'd6;
    localparam logic [2:0] PAIRS_P8  = 3'd4;
    localparam logic [2:0] PAIRS_P6  = 3'd3;

    function automatic logic [3:0] start_of(mode_t m);
        case (m)
            MODE_P12: return START_P12;
            MODE_P8:  return START_P8;
            MODE_P6:  return START_P6;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] pairs_of(mode_t m);
        case (m)
            MODE_P12: return PAIRS_P12;
            MODE_P8:  return PAIRS_P8;
            MODE_P6:  return PAIRS_P6;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ascon_perm_sched_2rc.sv
// Permutation sequencer: drives round-constant load/step, state enable and
// completion, with a one-entry pending slot for bubble-free chaining.
module ascon_perm_sched_2rc
    import ascon_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    input  logic [1:0] req_id,
    output logic       rc_init,
    output logic       rc_inc,
    output logic [3:0] rc_start,
    output logic       perm_en,
    output logic       done,
    output logic [1:0] done_id,
    output logic       err,
    output logic       busy
);

    state_t     state;
    logic [2:0] pairs_left;
    logic [1:0] cur_id;
    logic       pend_valid;
    mode_t      pend_mode;
    logic [1:0] pend_id;

    mode_t mode_in;
    logic  accept, legal, running, last, start_new, chain_pend, to_pend;

    assign mode_in   = mode_t'(req_mode);
    assign req_ready = !pend_valid;
    assign accept    = req_valid && req_ready;
    assign legal     = (mode_in != MODE_ILL);
    assign running   = (state == ST_RUN);
    assign last      = running && (pairs_left == 3'd1);

    // A fresh request starts immediately from IDLE, or chains (bypass) on the
    // last pair when nothing is pending; accept already implies an empty slot.
    assign start_new  = accept && legal && (!running || last);
    assign chain_pend = last && pend_valid;
    assign to_pend    = accept && legal && running && !last;

    assign rc_init  = start_new || chain_pend;
    assign rc_start = chain_pend ? start_of(pend_mode) :
                      start_new  ? start_of(mode_in)   : 4'd0;
    assign rc_inc   = running && !last;
    assign perm_en  = running;
    assign done     = last;
    assign done_id  = last ? cur_id : 2'd0;
    assign err      = accept && !legal;
    assign busy     = running || pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pairs_left <= 3'd0;
            cur_id     <= 2'd0;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_P12;
            pend_id    <= 2'd0;
        end else begin
            if (chain_pend) begin
                state      <= ST_RUN;
                pairs_left <= pairs_of(pend_mode);
                cur_id     <= pend_id;
                pend_valid <= 1'b0;
            end else if (start_new) begin
                state      <= ST_RUN;
                pairs_left <= pairs_of(mode_in);
                cur_id     <= req_id;
            end else if (running) begin
                pairs_left <= pairs_left - 3'd1;
                if (last)
                    state <= ST_IDLE;
            end
            if (to_pend) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_in;
                pend_id    <= req_id;
            end
        end
    end

endmodule
